// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks predicted branches in program order, checks resolutions,
// redirects fetch on mispredict. Optional perf counters under BR_RESOLVE_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int DEPTH      = 8,
  parameter int TAG_WIDTH  = 3,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_alloc_valid,
  output logic                  o_alloc_ready,
  input  logic [ADDR_WIDTH-1:0] i_alloc_pc,
  input  logic                  i_alloc_pred_taken,
  input  logic [ADDR_WIDTH-1:0] i_alloc_pred_target,
  output logic [TAG_WIDTH-1:0]  o_alloc_tag,
  input  logic                  i_res_valid,
  input  logic [TAG_WIDTH-1:0]  i_res_tag,
  input  logic                  i_res_taken,
  input  logic [ADDR_WIDTH-1:0] i_res_target,
  output logic                  o_redirect_valid,
  output logic [ADDR_WIDTH-1:0] o_redirect_pc,
  output logic [TAG_WIDTH-1:0]  o_flush_tag,
  output logic                  o_retire_valid,
  output logic                  o_retire_mispred,
  input  logic                  i_retire_ready,
`ifdef BR_RESOLVE_PERF_CNT_EN
  output logic [31:0]           o_perf_resolved_cnt,
  output logic [31:0]           o_perf_mispred_cnt,
`endif
  output logic [TAG_WIDTH:0]    o_count,
  output logic                  o_empty
);

  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_resolved;
  logic [DEPTH-1:0]      r_mispred;
  logic [DEPTH-1:0]      r_pred_taken;
  logic [ADDR_WIDTH-1:0] r_pc          [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pred_target [DEPTH];

  logic [TAG_WIDTH-1:0]  r_head;
  logic [TAG_WIDTH-1:0]  r_tail;
  logic [TAG_WIDTH:0]    r_count;
  logic                  r_redirect_valid;
  logic [ADDR_WIDTH-1:0] r_redirect_pc;
  logic [TAG_WIDTH-1:0]  r_flush_tag;

  logic                  w_res_hit;
  logic                  w_mis;
  logic                  w_mis_fire;
  logic [ADDR_WIDTH-1:0] w_correct_pc;
  logic                  w_alloc_fire;
  logic                  w_retire_fire;
  logic [TAG_WIDTH-1:0]  w_res_dist;
  logic [TAG_WIDTH:0]    w_count_next;
  logic [TAG_WIDTH-1:0]  w_tail_next;

  assign w_res_hit  = i_res_valid & r_valid[i_res_tag] & ~r_resolved[i_res_tag];
  assign w_mis      = (i_res_taken != r_pred_taken[i_res_tag]) |
                      (i_res_taken & (i_res_target != r_pred_target[i_res_tag]));
  assign w_mis_fire = w_res_hit & w_mis;
  assign w_correct_pc = i_res_taken ? i_res_target : (r_pc[i_res_tag] + ADDR_WIDTH'(4));
  assign w_res_dist = i_res_tag - r_head;

  assign o_alloc_ready = (r_count != (TAG_WIDTH+1)'(DEPTH)) & ~w_mis_fire;
  assign w_alloc_fire  = i_alloc_valid & o_alloc_ready;
  assign o_retire_valid   = r_valid[r_head] & r_resolved[r_head];
  assign o_retire_mispred = r_mispred[r_head];
  assign w_retire_fire    = o_retire_valid & i_retire_ready;

  assign o_alloc_tag      = r_tail;
  assign o_count          = r_count;
  assign o_empty          = (r_count == '0);
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_flush_tag      = r_flush_tag;

  always_comb begin
    w_count_next = r_count;
    w_tail_next  = r_tail;
    if (w_mis_fire) begin
      // Everything from head up to and including the mispredicted tag survives.
      w_count_next = (TAG_WIDTH+1)'(w_res_dist) + (TAG_WIDTH+1)'(1)
                     - {{TAG_WIDTH{1'b0}}, w_retire_fire};
      w_tail_next  = i_res_tag + TAG_WIDTH'(1);
    end else begin
      w_count_next = r_count + {{TAG_WIDTH{1'b0}}, w_alloc_fire}
                     - {{TAG_WIDTH{1'b0}}, w_retire_fire};
      if (w_alloc_fire) begin
        w_tail_next = r_tail + TAG_WIDTH'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [TAG_WIDTH-1:0] L_IDX = TAG_WIDTH'(gi);
      logic [TAG_WIDTH-1:0] w_age;
      logic                 w_younger;
      // Age relative to head orders entries even across pointer wrap.
      assign w_age     = L_IDX - r_head;
      assign w_younger = (w_age > w_res_dist);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid[gi]    <= 1'b0;
          r_resolved[gi] <= 1'b0;
          r_mispred[gi]  <= 1'b0;
        end else begin
          if (w_alloc_fire && (r_tail == L_IDX)) begin
            r_valid[gi]    <= 1'b1;
            r_resolved[gi] <= 1'b0;
            r_mispred[gi]  <= 1'b0;
          end
          if (w_retire_fire && (r_head == L_IDX)) begin
            r_valid[gi] <= 1'b0;
          end
          if (w_res_hit && (i_res_tag == L_IDX)) begin
            r_resolved[gi] <= 1'b1;
            r_mispred[gi]  <= w_mis;
          end
          if (w_mis_fire && w_younger) begin
            r_valid[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_alloc_fire) begin
      r_pc[r_tail]          <= i_alloc_pc;
      r_pred_taken[r_tail]  <= i_alloc_pred_taken;
      r_pred_target[r_tail] <= i_alloc_pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush_tag      <= '0;
    end else begin
      r_tail           <= w_tail_next;
      r_count          <= w_count_next;
      r_redirect_valid <= w_mis_fire;
      if (w_retire_fire) begin
        r_head <= r_head + TAG_WIDTH'(1);
      end
      if (w_mis_fire) begin
        r_redirect_pc <= w_correct_pc;
        r_flush_tag   <= i_res_tag;
      end
    end
  end

`ifdef BR_RESOLVE_PERF_CNT_EN
  logic [31:0] r_perf_resolved_cnt;
  logic [31:0] r_perf_mispred_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_resolved_cnt <= '0;
      r_perf_mispred_cnt  <= '0;
    end else begin
      if (w_res_hit) begin
        r_perf_resolved_cnt <= r_perf_resolved_cnt + 32'd1;
      end
      if (w_mis_fire) begin
        r_perf_mispred_cnt <= r_perf_mispred_cnt + 32'd1;
      end
    end
  end

  assign o_perf_resolved_cnt = r_perf_resolved_cnt;
  assign o_perf_mispred_cnt  = r_perf_mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_alloc_valid = 1'b0;
  logic        o_alloc_ready;
  logic [31:0] i_alloc_pc = '0;
  logic        i_alloc_pred_taken = 1'b0;
  logic [31:0] i_alloc_pred_target = '0;
  logic [2:0]  o_alloc_tag;
  logic        i_res_valid = 1'b0;
  logic [2:0]  i_res_tag = '0;
  logic        i_res_taken = 1'b0;
  logic [31:0] i_res_target = '0;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic [2:0]  o_flush_tag;
  logic        o_retire_valid;
  logic        o_retire_mispred;
  logic        i_retire_ready = 1'b0;
  logic [3:0]  o_count;
  logic        o_empty;

  int n_pass = 0;
  int n_total = 0;

  branch_resolve_unit #(.DEPTH(8), .TAG_WIDTH(3), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_alloc_valid(i_alloc_valid), .o_alloc_ready(o_alloc_ready),
    .i_alloc_pc(i_alloc_pc), .i_alloc_pred_taken(i_alloc_pred_taken),
    .i_alloc_pred_target(i_alloc_pred_target), .o_alloc_tag(o_alloc_tag),
    .i_res_valid(i_res_valid), .i_res_tag(i_res_tag), .i_res_taken(i_res_taken),
    .i_res_target(i_res_target),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_flush_tag(o_flush_tag),
    .o_retire_valid(o_retire_valid), .o_retire_mispred(o_retire_mispred),
    .i_retire_ready(i_retire_ready),
    .o_count(o_count), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=0x%0h", tag, got);
    end else begin
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_alloc_valid = 1'b0;
    i_res_valid = 1'b0;
    i_retire_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                       input logic [2:0] exp_tag);
    i_alloc_valid = 1'b1;
    i_alloc_pc = pc;
    i_alloc_pred_taken = pt;
    i_alloc_pred_target = tgt;
    #1;
    chk($sformatf("alloc_tag_%0d", exp_tag), {61'd0, o_alloc_tag}, {61'd0, exp_tag});
    step();
    i_alloc_valid = 1'b0;
  endtask

  task automatic resolve(input logic [2:0] tag, input logic tk, input logic [31:0] tgt);
    i_res_valid = 1'b1;
    i_res_tag = tag;
    i_res_taken = tk;
    i_res_target = tgt;
    step();
    i_res_valid = 1'b0;
  endtask

  task automatic retire();
    i_retire_ready = 1'b1;
    step();
    i_retire_ready = 1'b0;
  endtask

  logic [2:0] exp_head;
  logic [2:0] exp_tail;

  initial begin
    #2;
    do_reset();
    chk("rst_alloc_ready", {63'd0, o_alloc_ready}, 64'd1);
    chk("rst_empty", {63'd0, o_empty}, 64'd1);
    chk("rst_retire_valid", {63'd0, o_retire_valid}, 64'd0);
    chk("rst_alloc_tag", {61'd0, o_alloc_tag}, 64'd0);
    chk("rst_count", {60'd0, o_count}, 64'd0);
    chk("rst_redirect_valid", {63'd0, o_redirect_valid}, 64'd0);
    chk("rst_redirect_pc", {32'd0, o_redirect_pc}, 64'd0);

    // Fill all eight entries.
    for (int i = 0; i < 8; i++) begin
      alloc(32'(i * 16), 1'b0, 32'(i * 16 + 4), 3'(i));
    end
    chk("full_count", {60'd0, o_count}, 64'd8);
    chk("full_alloc_ready", {63'd0, o_alloc_ready}, 64'd0);
    chk("full_empty", {63'd0, o_empty}, 64'd0);
    resolve(3'd0, 1'b0, 32'd0);
    chk("full_redirect_none", {63'd0, o_redirect_valid}, 64'd0);
    chk("full_retire_valid", {63'd0, o_retire_valid}, 64'd1);
    // Retire while full; a concurrent alloc must be refused.
    i_retire_ready = 1'b1;
    i_alloc_valid = 1'b1;
    #1;
    chk("full_retire_alloc_ready", {63'd0, o_alloc_ready}, 64'd0);
    step();
    i_retire_ready = 1'b0;
    i_alloc_valid = 1'b0;
    chk("retire_count", {60'd0, o_count}, 64'd7);
    chk("retire_alloc_ready", {63'd0, o_alloc_ready}, 64'd1);
    chk("retire_alloc_tag", {61'd0, o_alloc_tag}, 64'd0);

    // Steady alloc+retire at count 7, wrapping the pointers.
    resolve(3'd1, 1'b0, 32'd0);
    exp_head = 3'd1;
    exp_tail = 3'd0;
    for (int k = 0; k < 12; k++) begin
      i_alloc_valid = 1'b1;
      i_alloc_pc = 32'h1000 + 32'(k * 4);
      i_alloc_pred_taken = 1'b0;
      i_alloc_pred_target = 32'h1004 + 32'(k * 4);
      i_retire_ready = 1'b1;
      i_res_valid = 1'b1;
      i_res_tag = exp_head + 3'd1;
      i_res_taken = 1'b0;
      #1;
      chk($sformatf("wrap_tag_%0d", k), {61'd0, o_alloc_tag}, {61'd0, exp_tail});
      chk($sformatf("wrap_retv_%0d", k), {63'd0, o_retire_valid}, 64'd1);
      step();
      chk($sformatf("wrap_count_%0d", k), {60'd0, o_count}, 64'd7);
      exp_head = exp_head + 3'd1;
      exp_tail = exp_tail + 3'd1;
    end
    i_alloc_valid = 1'b0;
    i_retire_ready = 1'b0;
    i_res_valid = 1'b0;
    chk("wrap_redirect_none", {63'd0, o_redirect_valid}, 64'd0);

    // Correct not-taken prediction.
    do_reset();
    alloc(32'h100, 1'b0, 32'h104, 3'd0);
    resolve(3'd0, 1'b0, 32'd0);
    chk("nt_redirect_valid", {63'd0, o_redirect_valid}, 64'd0);
    chk("nt_retire_valid", {63'd0, o_retire_valid}, 64'd1);
    chk("nt_retire_mispred", {63'd0, o_retire_mispred}, 64'd0);

    // Mispredict on tag 1 with a concurrent alloc attempt.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(32'(i * 16), 1'b0, 32'(i * 16 + 4), 3'(i));
    end
    i_alloc_valid = 1'b1;
    i_res_valid = 1'b1;
    i_res_tag = 3'd1;
    i_res_taken = 1'b1;
    i_res_target = 32'h200;
    #1;
    chk("mis_alloc_ready", {63'd0, o_alloc_ready}, 64'd0);
    step();
    i_alloc_valid = 1'b0;
    i_res_valid = 1'b0;
    chk("mis_redirect_valid", {63'd0, o_redirect_valid}, 64'd1);
    chk("mis_redirect_pc", {32'd0, o_redirect_pc}, 64'h200);
    chk("mis_flush_tag", {61'd0, o_flush_tag}, 64'd1);
    chk("mis_tail", {61'd0, o_alloc_tag}, 64'd2);
    chk("mis_count", {60'd0, o_count}, 64'd2);
    step();
    chk("mis_pulse_end", {63'd0, o_redirect_valid}, 64'd0);
    resolve(3'd3, 1'b1, 32'h500);
    chk("squashed_redirect", {63'd0, o_redirect_valid}, 64'd0);
    chk("squashed_count", {60'd0, o_count}, 64'd2);
    chk("squashed_retv", {63'd0, o_retire_valid}, 64'd0);
    // Older branch mispredicts after the younger one.
    alloc(32'h700, 1'b0, 32'h704, 3'd2);
    resolve(3'd0, 1'b1, 32'h300);
    chk("older_redirect_pc", {32'd0, o_redirect_pc}, 64'h300);
    chk("older_flush_tag", {61'd0, o_flush_tag}, 64'd0);
    chk("older_count", {60'd0, o_count}, 64'd1);
    chk("older_tail", {61'd0, o_alloc_tag}, 64'd1);
    chk("older_retire_mispred", {63'd0, o_retire_mispred}, 64'd1);
    retire();
    chk("older_empty", {63'd0, o_empty}, 64'd1);

    // Taken with wrong target, then not-taken at the top of the address space.
    do_reset();
    alloc(32'h40, 1'b1, 32'h80, 3'd0);
    resolve(3'd0, 1'b1, 32'h90);
    chk("tgt_redirect_valid", {63'd0, o_redirect_valid}, 64'd1);
    chk("tgt_redirect_pc", {32'd0, o_redirect_pc}, 64'h90);
    retire();
    alloc(32'hFFFF_FFFC, 1'b1, 32'h10, 3'd1);
    resolve(3'd1, 1'b0, 32'h0);
    chk("wrap_redirect_pc", {32'd0, o_redirect_pc}, 64'h0);
    chk("wrap_flush_tag", {61'd0, o_flush_tag}, 64'd1);

    // Async reset with a redirect outstanding.
    do_reset();
    alloc(32'h20, 1'b0, 32'h24, 3'd0);
    alloc(32'h30, 1'b0, 32'h34, 3'd1);
    resolve(3'd0, 1'b1, 32'h400);
    chk("pre_rst_redirect", {63'd0, o_redirect_valid}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_redirect", {63'd0, o_redirect_valid}, 64'd0);
    chk("async_rst_redirect_pc", {32'd0, o_redirect_pc}, 64'd0);
    chk("async_rst_count", {60'd0, o_count}, 64'd0);
    chk("async_rst_alloc_ready", {63'd0, o_alloc_ready}, 64'd1);
    chk("async_rst_tag", {61'd0, o_alloc_tag}, 64'd0);
    step();
    rst = 1'b0;
    chk("post_rst_retv", {63'd0, o_retire_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side counterpart of the fetch-stage next-PC predictor.
- Fetch allocates one entry per predicted branch/jump: PC, predicted direction, predicted target.
- Execute returns the actual outcome by tag. The block compares it against the prediction, issues a registered redirect and flush on mismatch, and frees entries in program order at retire.
- Sits between fetch/dispatch, the branch ALU, and the ROB.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of two, at least 2.
- TAG_WIDTH, 3, log2(DEPTH); width of branch tags.
- ADDR_WIDTH, 32, PC/target width; matches `ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- alloc_valid  input  1  fetch presents a predicted branch.
- alloc_ready  output  1  entry available; allocation fires on valid & ready.
- alloc_pc  input  ADDR_WIDTH  PC of the branch.
- alloc_pred_taken  input  1  predicted direction; 1 for jal/jalr.
- alloc_pred_target  input  ADDR_WIDTH  predicted next PC.
- alloc_tag  output  TAG_WIDTH  tag assigned; equals the tail pointer.
- res_valid  input  1  branch ALU resolution strobe; at most one per cycle.
- res_tag  input  TAG_WIDTH  tag being resolved.
- res_taken  input  1  actual direction.
- res_target  input  ADDR_WIDTH  actual taken target.
- redirect_valid  output  1  one-cycle pulse on mispredict.
- redirect_pc  output  ADDR_WIDTH  corrected fetch PC.
- flush_tag  output  TAG_WIDTH  mispredicted tag; all younger entries are squashed.
- retire_valid  output  1  head entry valid and resolved.
- retire_mispred  output  1  head entry was mispredicted.
- retire_ready  input  1  ROB accepts; head pops on valid & ready.
- count  output  TAG_WIDTH+1  occupied entries.
- empty  output  1  count == 0.

Behaviour:
- Storage: circular buffer with head, tail and count registers.
- Per entry: valid, resolved, mispred, pc, pred_taken, pred_target.
- Reset (async, rst=1):
  - all entry valid/resolved/mispred = 0; head = tail = count = 0.
  - redirect_valid = 0, redirect_pc = 0, flush_tag = 0.
  - Resulting outputs: alloc_ready = 1, empty = 1, retire_valid = 0, alloc_tag = 0.
  - Reset mid-operation discards all entries; a redirect pending in the same cycle is lost.
- Mispredict detection (combinational on res_valid for a valid, unresolved entry):
  - mis = (res_taken != pred_taken) | (res_taken & (res_target != pred_target)).
  - Correct PC = res_taken ? res_target : pc + 4, modulo 2^ADDR_WIDTH; wraps at 0xFFFFFFFC -> 0.
- Resolution with res_tag naming an invalid or already-resolved entry: ignored, no state change.
- Resolve, no mispredict: entry.resolved <= 1 next edge.
- Resolve with mispredict (all on the next edge):
  - entry.resolved <= 1, entry.mispred <= 1.
  - tail <= res_tag + 1 mod DEPTH.
  - Entries strictly younger than res_tag (from res_tag+1 up to old tail) are invalidated.
  - count <= ((res_tag - head) mod DEPTH) + 1 - retire_fire.
  - redirect_valid <= 1, redirect_pc <= correct PC, flush_tag <= res_tag.
- redirect_valid is a single-cycle pulse: 1-cycle latency from res_valid.
- alloc_ready = (count != DEPTH) & !(res_valid & mis), combinational. A fetch allocation in a mispredict cycle is not accepted.
- alloc_tag = tail.
- Allocation writes the entry at tail: valid=1, resolved=0, mispred=0. Then tail++ (wraps DEPTH-1 -> 0) and count++.
- retire_valid = head.valid & head.resolved; retire_mispred = head.mispred.
- Retire fire: head.valid <= 0, head++ (wraps), count--.
- Simultaneous alloc and retire: count unchanged, both pointers advance.
- Full (count == DEPTH): alloc_ready = 0; a retire in that cycle does not enable a same-cycle alloc.
- Resolving the head and retiring it in the same cycle is impossible: resolved is registered.
- An older branch mispredicting after a younger one flushes the younger entry and any younger redirect state. A later resolve to a squashed tag is ignored.

Optional Feature:
- Macro: BR_RESOLVE_PERF_CNT_EN.
- Defined: adds outputs perf_resolved_cnt[31:0] and perf_mispred_cnt[31:0].
  - Incremented on each accepted resolution and each mispredict respectively.
  - Both wrap at 2^32 and reset to 0 on rst.
- Undefined: ports and counters absent; no other behavioural change.

Test Plan:
- Reset, then 8 allocs with no retire -> tags 0..7, count=8, alloc_ready=0. Retire head after resolving tag 0 -> count=7, alloc_ready=1.
- Alloc pc=0x100, pred_taken=0, pred_target=0x104; resolve tag 0 with taken=0 -> no redirect, retire_valid=1, retire_mispred=0.
- Alloc tags 0..3; resolve tag 1 with taken=1, target=0x200 against pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x200, flush_tag=1; tail=2, count=2. A later resolve of tag 3 is ignored.
- Taken misdirect: pred_taken=1, pred_target=0x80, actual target 0x90 -> redirect_pc=0x90. Not-taken mispredict at pc=0xFFFFFFFC -> redirect_pc=0x00000000.
- Wrap and simultaneous events: fill to 8, then alloc and retire concurrently for 12 cycles -> tags wrap 7->0, count stays at its value.
- Mispredict with alloc_valid=1 in the same cycle -> alloc_ready=0 and the alloc is not accepted. Assert rst mid-stream with a redirect pending -> all outputs return to reset values immediately.
